wb_uart_tx: RTL and testbench

//  Wishbone (pipelined, classic-ack) slave giving the SoC CPU a transmit-only UART.

---
 rtl/wb_uart_pkg.sv | 15 +
 rtl/uart_tx_serializer.sv | 93 +++++++++
 rtl/wb_uart_tx.sv | 65 ++++++
 tb/tb_wb_uart_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_pkg.sv
// Shared register map and TX state encoding for the Wishbone UART transmitter.
package wb_uart_pkg;

  localparam logic [1:0] ADDR_TXDATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS     = 2'd1;
  localparam int         STATUS_BUSY_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer, LSB first: owns the TX FSM, baud counter and shift register.
module uart_tx_serializer
  import wb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int unsigned      CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             tx, tx_next;
  logic             bit_done;

  assign bit_done = (baud_cnt == CNT_MAX);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

  // NOTE: defaults first; a branch that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    baud_cnt_next = bit_done ? '0 : baud_cnt + 1'b1;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    tx_next       = tx;

    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        if (i_start) begin
          state_next = START;
          shift_next = i_byte;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
          tx_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);
  assign o_tx   = tx;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone pipelined slave fronting a transmit-only UART: decode, stall and registered ack/data.
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [1:0] i_wb_addr,
  input  logic [7:0] i_wb_data,
  output logic       o_wb_ack,
  output logic       o_wb_stall,
  output logic [7:0] o_wb_data,
  output logic       o_uart_tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic       busy;
  logic       req;
  logic       accept;
  logic       start;
  logic [7:0] status_word;
  logic [7:0] rdata_next;

  // Only a TXDATA write can stall; it waits for the serializer rather than dropping a byte.
  assign req        = i_wb_cyc & i_wb_stb;
  assign o_wb_stall = req & i_wb_we & (i_wb_addr == ADDR_TXDATA) & busy;
  assign accept     = req & ~o_wb_stall;
  assign start      = accept & i_wb_we & (i_wb_addr == ADDR_TXDATA);

  always_comb begin
    status_word                  = '0;
    status_word[STATUS_BUSY_BIT] = busy;
    rdata_next                   = '0;
    if (accept && !i_wb_we && (i_wb_addr == ADDR_STATUS)) rdata_next = status_word;
  end

  // Read data is zero on every non-ack cycle so the shared read bus can be OR-combined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= accept;
      o_wb_data <= rdata_next;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk    (clk),
    .reset  (reset),
    .i_start(start),
    .i_byte (i_wb_data),
    .o_busy (busy),
    .o_tx   (o_uart_tx)
  );

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench: frame-timing model checked every cycle plus hand-computed line/bus literals.
module tb_wb_uart_tx;

  localparam int CPB   = 434;
  localparam int FRAME = 10 * CPB;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       cyc   = 1'b0;
  logic       stb   = 1'b0;
  logic       we    = 1'b0;
  logic [1:0] addr  = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic       ack;
  logic       stall;
  logic [7:0] rdata;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .i_wb_we   (we),
    .i_wb_addr (addr),
    .i_wb_data (wdata),
    .o_wb_ack  (ack),
    .o_wb_stall(stall),
    .o_wb_data (rdata),
    .o_uart_tx (uart_tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame accepted on edge a occupies edges a..a+FRAME-1; bit k = elapsed / CPB.
  int         e       = 0;
  int         a       = 0;
  bit         f_act   = 1'b0;
  logic [7:0] f_byte  = 8'h00;
  logic       m_ack   = 1'b0;
  logic [7:0] m_data  = 8'h00;

  function automatic bit m_busy();
    return f_act && ((e - a) < FRAME);
  endfunction

  function automatic logic m_line();
    int k;
    if (!m_busy()) return 1'b1;
    k = (e - a) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return f_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic m_stall();
    return cyc && stb && we && (addr == 2'd0) && m_busy();
  endfunction

  initial forever begin
    bit busy_pre, st, acc;
    @(posedge clk or posedge reset);
    if (reset) begin
      f_act  = 1'b0;
      m_ack  = 1'b0;
      m_data = 8'h00;
    end else begin
      busy_pre = m_busy();
      st       = cyc && stb && we && (addr == 2'd0) && busy_pre;
      acc      = cyc && stb && !st;
      m_ack    = acc;
      m_data   = (acc && !we && addr == 2'd1) ? {7'b0, busy_pre} : 8'h00;
      e        = e + 1;
      if (acc && we && addr == 2'd0) begin
        f_act  = 1'b1;
        a      = e;
        f_byte = wdata;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("line", uart_tx, m_line());
    check("ack", ack, m_ack);
    check("rdata", rdata, m_data);
    check("stall", stall, m_stall());
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic wb_req(input logic w, input logic [1:0] ad, input logic [7:0] d,
                        output logic got_ack, output logic [7:0] rd, output int stalls);
    cyc = 1'b1; stb = 1'b1; we = w; addr = ad; wdata = d;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 6000) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 6000) check("stall_timeout", stalls, 0);
    @(posedge clk);
    #1;
    got_ack = ack;
    rd      = rdata;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // bits[0] is the start bit, bits[9] the stop bit; sampled mid-bit.
  task automatic sample_frame(input logic [9:0] bits, input string nm);
    repeat (CPB / 2) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s_bit%0d", nm, k), uart_tx, bits[k]);
      if (k < 9) begin
        repeat (CPB) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ga;
    logic [7:0] rd;
    int         st;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_line", uart_tx, 1'b1);
    check("rst_ack", ack, 1'b0);
    check("rst_data", rdata, 8'h00);
    reset = 1'b0;
    step(5);

    // 0xA5 frame: line 0,1,0,1,0,0,1,0,1,1
    wb_req(1'b1, 2'd0, 8'hA5, ga, rd, st);
    check("wr_a5_ack", ga, 1'b1);
    check("wr_a5_stalls", st, 0);
    sample_frame(10'b11_0100_1010, "a5");
    wb_req(1'b0, 2'd1, 8'h00, ga, rd, st);
    check("status_busy_ack", ga, 1'b1);
    check("status_busy_data", rd, 8'h01);
    step(400);
    wb_req(1'b0, 2'd1, 8'h00, ga, rd, st);
    check("status_idle_data", rd, 8'h00);

    // Back-to-back: 0x3C is stalled for the whole 0x96 frame, then follows it.
    wb_req(1'b1, 2'd0, 8'h96, ga, rd, st);
    wb_req(1'b1, 2'd0, 8'h3C, ga, rd, st);
    check("wr_3c_stalls", st, FRAME);
    check("wr_3c_ack", ga, 1'b1);
    sample_frame(10'b10_0111_1000, "3c");
    wb_req(1'b1, 2'd1, 8'hFF, ga, rd, st);
    check("wr_status_busy_stalls", st, 0);
    check("wr_status_busy_ack", ga, 1'b1);
    step(500);

    // Reserved and non-data accesses.
    wb_req(1'b0, 2'd2, 8'h00, ga, rd, st);
    check("rd2_ack", ga, 1'b1);
    check("rd2_data", rd, 8'h00);
    wb_req(1'b0, 2'd3, 8'h00, ga, rd, st);
    check("rd3_data", rd, 8'h00);
    wb_req(1'b0, 2'd0, 8'h00, ga, rd, st);
    check("rd0_data", rd, 8'h00);
    wb_req(1'b1, 2'd2, 8'h55, ga, rd, st);
    check("wr2_ack", ga, 1'b1);
    wb_req(1'b1, 2'd3, 8'hAA, ga, rd, st);
    check("wr3_ack", ga, 1'b1);
    step(100);
    check("reserved_no_tx", uart_tx, 1'b1);

    // Strobe without cyc: ignored entirely.
    cyc = 1'b0; stb = 1'b1; we = 1'b1; addr = 2'd0; wdata = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("nocyc_ack", ack, 1'b0);
    end
    stb = 1'b0; we = 1'b0;
    step(500);
    check("nocyc_no_tx", uart_tx, 1'b1);

    // Reset mid-frame with an ack outstanding.
    wb_req(1'b1, 2'd0, 8'h00, ga, rd, st);
    check("pre_rst_ack", ga, 1'b1);
    check("pre_rst_line", uart_tx, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("midrst_line", uart_tx, 1'b1);
    check("midrst_ack", ack, 1'b0);
    check("midrst_data", rdata, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    step(20);
    check("post_rst_line", uart_tx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
